// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite register file: response codes,
// FSM state types and a small response-selection helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  // In-range accesses answer OKAY, anything outside the map answers DECERR.
  function automatic logic [1:0] resp_for(input logic in_range);
    return in_range ? RESP_OKAY : RESP_DECERR;
  endfunction

endpackage

// File: rtl/axi_lite_regfile_wr.sv
// Write channel of the register file: captures AW and W independently,
// issues a single-cycle commit once both are held, then drives the B response.
// Address decode lives in the top; it feeds back whether the captured
// address is inside the register map.
module axi_lite_regfile_wr
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    active,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    cmt_valid,
  output logic [ADDR_WIDTH-1:0]   cmt_addr,
  output logic [DATA_WIDTH-1:0]   cmt_data,
  output logic [DATA_WIDTH/8-1:0] cmt_strb,
  input  logic                    cmt_addr_ok
);

  wr_state_e               state_q, state_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic [1:0]              bresp_q, bresp_d;

  // State register plus captured channel contents; reset drops any half-done write.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= WR_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Next state: commit moves to the response phase, bready returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE: if (cmt_valid) state_d = WR_RESP;
      WR_RESP: if (bready)    state_d = WR_IDLE;
      default: state_d = WR_IDLE;
    endcase
  end

  // Channel capture and response latching; AW and W may arrive in any order.
  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    bresp_d   = bresp_q;
    if (awvalid && awready) begin
      aw_done_d = 1'b1;
      addr_d    = awaddr;
    end
    if (wvalid && wready) begin
      w_done_d = 1'b1;
      data_d   = wdata;
      strb_d   = wstrb;
    end
    if (cmt_valid) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      bresp_d   = resp_for(cmt_addr_ok);
    end
  end

  // Outputs: readies only while idle and the channel is still empty.
  always_comb begin
    awready   = active && (state_q == WR_IDLE) && !aw_done_q;
    wready    = active && (state_q == WR_IDLE) && !w_done_q;
    cmt_valid = active && (state_q == WR_IDLE) && aw_done_q && w_done_q;
    bvalid    = (state_q == WR_RESP);
    bresp     = bresp_q;
    cmt_addr  = addr_q;
    cmt_data  = data_q;
    cmt_strb  = strb_q;
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register file: decode, byte-strobed storage and the
// read path. The write handshake is delegated to axi_lite_regfile_wr.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int AW_LSB = $clog2(BYTES);
  localparam int IDX_W  = $clog2(NUM_REGS);

  // Any address bit above the word index set means the access is outside the map.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> (AW_LSB + IDX_W)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> AW_LSB);
  endfunction

  logic                    active_q, active_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
  rd_state_e               rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                    cmt_valid;
  logic [ADDR_WIDTH-1:0]   cmt_addr;
  logic [DATA_WIDTH-1:0]   cmt_data;
  logic [BYTES-1:0]        cmt_strb;
  logic                    cmt_addr_ok;
  logic [IDX_W-1:0]        cmt_idx;
  logic                    rd_ok;
  logic [IDX_W-1:0]        rd_idx;
  logic                    ar_hs;
  logic                    unused_prot;

  assign unused_prot = ^{awprot, arprot};
  assign active_d    = 1'b1;
  assign cmt_addr_ok = addr_in_range(cmt_addr);
  assign cmt_idx     = addr_index(cmt_addr);
  assign rd_ok       = addr_in_range(araddr);
  assign rd_idx      = addr_index(araddr);
  assign ar_hs       = arvalid && arready;

  axi_lite_regfile_wr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .active      (active_q),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .cmt_valid   (cmt_valid),
    .cmt_addr    (cmt_addr),
    .cmt_data    (cmt_data),
    .cmt_strb    (cmt_strb),
    .cmt_addr_ok (cmt_addr_ok)
  );

  // Holds the readies low during reset until the first edge after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) active_q <= 1'b0;
    else          active_q <= active_d;
  end

  // Register storage and the one-cycle write strobe.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      regs_q     <= '{default: RESET_VAL};
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Byte-lane merge of a committed write; out-of-range commits touch nothing.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (cmt_valid && cmt_addr_ok) begin
      for (int b = 0; b < BYTES; b++) begin
        if (cmt_strb[b]) regs_d[cmt_idx][b*8 +: 8] = cmt_data[b*8 +: 8];
      end
      wr_pulse_d[cmt_idx] = 1'b1;
    end
  end

  // Read state register and latched response; regs_q is sampled pre-write.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Read next state: AR handshake enters the data phase, rready leaves it.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (ar_hs)  rd_state_d = RD_DATA;
      RD_DATA: if (rready) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read data capture at the AR handshake; out-of-range reads return zero.
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rdata_d = rd_ok ? regs_q[rd_idx] : '0;
      rresp_d = resp_for(rd_ok);
    end
  end

  // Read channel outputs.
  always_comb begin
    arready  = active_q && (rd_state_q == RD_IDLE);
    rvalid   = (rd_state_q == RD_DATA);
    rdata    = rdata_q;
    rresp    = rresp_q;
    wr_pulse = wr_pulse_q;
  end

  // Flattened view of the register contents.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: scenario tasks drive the AXI-Lite
// channels, push expected responses to queues and compare as they appear.
module tb_axi_lite_regfile;

  localparam int          AW = 32;
  localparam int          DW = 32;
  localparam int          NR = 16;
  localparam logic [31:0] RV = 32'h5A5A_0000;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [AW-1:0]     awaddr = '0;
  logic [2:0]        awprot = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [DW-1:0]     wdata = '0;
  logic [DW/8-1:0]   wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [AW-1:0]     araddr = '0;
  logic [2:0]        arprot = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [NR*DW-1:0]  reg_q;
  logic [NR-1:0]     wr_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [1:0]    resp;
    logic [NR-1:0] pulse;
  } bexp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rexp_t;

  logic [DW-1:0] mdl [NR];
  bexp_t         b_exp [$];
  rexp_t         r_exp [$];

  axi_lite_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RESET_VAL  (RV)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .awaddr   (awaddr),
    .awprot   (awprot),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arprot   (arprot),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int first_reg_mismatch();
    for (int i = 0; i < NR; i++) begin
      if (reg_q[i*DW +: DW] !== mdl[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic in_map(input logic [AW-1:0] a);
    return a < AW'(NR * 4);
  endfunction

  // Drive AW until accepted (bounded); returns at the negedge after the handshake.
  task automatic send_aw(input logic [AW-1:0] a, input int delay);
    bit done = 0;
    repeat (delay) @(negedge aclk);
    awaddr  = a;
    awvalid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (awready) done = 1;
      @(negedge aclk);
    end
    awvalid = 1'b0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL aw_timeout: awready got 0 expected 1");
    end
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input int delay);
    bit done = 0;
    repeat (delay) @(negedge aclk);
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (wready) done = 1;
      @(negedge aclk);
    end
    wvalid = 1'b0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL w_timeout: wready got 0 expected 1");
    end
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    bit done = 0;
    araddr  = a;
    arvalid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (arready) done = 1;
      @(negedge aclk);
    end
    arvalid = 1'b0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL ar_timeout: arready got 0 expected 1");
    end
  endtask

  // Record the expected outcome of a write in the model and scoreboard.
  task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    bexp_t e;
    int    idx;
    idx = int'(a[5:2]);
    if (in_map(a)) begin
      for (int b = 0; b < DW/8; b++) begin
        if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
      end
      e.resp  = 2'b00;
      e.pulse = NR'(1) << idx;
    end else begin
      e.resp  = 2'b11;
      e.pulse = '0;
    end
    b_exp.push_back(e);
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s, input int aw_delay, input int w_delay);
    expect_write(a, d, s);
    fork
      send_aw(a, aw_delay);
      send_w(d, s, w_delay);
    join
  endtask

  task automatic axi_read(input logic [AW-1:0] a);
    rexp_t e;
    e.data = in_map(a) ? mdl[int'(a[5:2])] : '0;
    e.resp = in_map(a) ? 2'b00 : 2'b11;
    r_exp.push_back(e);
    send_ar(a);
  endtask

  // Wait for B, compare against the scoreboard head, then accept it.
  task automatic collect_b(input bit chk_pulse);
    bexp_t e;
    bit    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      if (bvalid) begin
        seen = 1;
        e = b_exp.pop_front();
        tests_run++;
        if (bresp !== e.resp) begin
          tests_failed++;
          $display("[TB] FAIL bresp: got %b expected %b", bresp, e.resp);
        end
        if (chk_pulse) begin
          tests_run++;
          if (wr_pulse !== e.pulse) begin
            tests_failed++;
            $display("[TB] FAIL wr_pulse: got %h expected %h", wr_pulse, e.pulse);
          end
        end
        bready = 1'b1;
      end
      @(negedge aclk);
    end
    bready = 1'b0;
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL b_timeout: bvalid got 0 expected 1");
    end
  endtask

  task automatic collect_r();
    rexp_t e;
    bit    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      if (rvalid) begin
        seen = 1;
        e = r_exp.pop_front();
        tests_run++;
        if (rdata !== e.data || rresp !== e.resp) begin
          tests_failed++;
          $display("[TB] FAIL rdata: got %h/%b expected %h/%b", rdata, rresp, e.data, e.resp);
        end
        rready = 1'b1;
      end
      @(negedge aclk);
    end
    rready = 1'b0;
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL r_timeout: rvalid got 0 expected 1");
    end
  endtask

  task automatic test_reset();
    foreach (mdl[i]) mdl[i] = RV;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    tests_run++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || wr_pulse !== '0 ||
        bresp !== 2'b00 || rresp !== 2'b00 || rdata !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b pulse=%h bresp=%b rresp=%b rdata=%h expected all 0",
               awready, wready, arready, bvalid, rvalid, wr_pulse, bresp, rresp, rdata);
    end
    tests_run++;
    if (first_reg_mismatch() != -1) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs: reg %0d got %h expected %h", first_reg_mismatch(),
               reg_q[first_reg_mismatch()*DW +: DW], RV);
    end
    aresetn = 1'b1;
    #1;
    tests_run++;
    if (arready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ready_before_edge: got %b expected 0", arready);
    end
    @(negedge aclk);
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL ready_after_release: got %b expected 111", {awready, wready, arready});
    end
  endtask

  task automatic test_aw_then_w();
    bexp_t e;
    expect_write(32'h8, 32'hDEAD_BEEF, 4'hF);
    awaddr  = 32'h8;
    awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    tests_run++;
    if (awready !== 1'b0 || wready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL aw_captured: got aw/w ready %b%b expected 01", awready, wready);
    end
    repeat (2) @(negedge aclk);
    wdata  = 32'hDEAD_BEEF;
    wstrb  = 4'hF;
    wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bvalid_early: got %b expected 0", bvalid);
    end
    @(negedge aclk);
    e = b_exp.pop_front();
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== e.resp || wr_pulse !== e.pulse) begin
      tests_failed++;
      $display("[TB] FAIL b_after_w: got bv=%b bresp=%b pulse=%h expected 1/%b/%h",
               bvalid, bresp, wr_pulse, e.resp, e.pulse);
    end
    tests_run++;
    if (reg_q[2*DW +: DW] !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("[TB] FAIL reg2: got %h expected deadbeef", reg_q[2*DW +: DW]);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    tests_run++;
    if (bvalid !== 1'b0 || wr_pulse !== '0 || {awready, wready} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL b_release: got bv=%b pulse=%h rdy=%b%b expected 0/0000/11",
               bvalid, wr_pulse, awready, wready);
    end
  endtask

  task automatic test_strobe();
    axi_write(32'h4, 32'h1122_3344, 4'hF, 0, 0);
    collect_b(1);
    axi_write(32'h4, 32'hAABB_CCDD, 4'h5, 0, 0);
    collect_b(1);
    tests_run++;
    if (reg_q[1*DW +: DW] !== 32'h11BB_33DD) begin
      tests_failed++;
      $display("[TB] FAIL strobe_merge: got %h expected 11bb33dd", reg_q[1*DW +: DW]);
    end
    axi_write(32'h4, 32'hFFFF_FFFF, 4'h0, 0, 0);
    collect_b(1);
    axi_write(32'h10, 32'h0BAD_F00D, 4'hF, 3, 0);
    collect_b(1);
    axi_write(32'h3C, 32'h1234_5678, 4'hA, 0, 2);
    collect_b(1);
    tests_run++;
    if (first_reg_mismatch() != -1) begin
      tests_failed++;
      $display("[TB] FAIL strobe_regs: reg %0d got %h expected %h", first_reg_mismatch(),
               reg_q[first_reg_mismatch()*DW +: DW], mdl[first_reg_mismatch()]);
    end
    axi_read(32'h4);
    collect_r();
    axi_read(32'h0B);
    collect_r();
    axi_read(32'h3C);
    collect_r();
  endtask

  task automatic test_out_of_range();
    axi_read(32'h100);
    collect_r();
    axi_read(32'h40);
    collect_r();
    axi_write(32'h100, 32'hCAFE_CAFE, 4'hF, 0, 0);
    collect_b(1);
    axi_write(32'h8000_0000, 32'hCAFE_CAFE, 4'hF, 1, 0);
    collect_b(1);
    tests_run++;
    if (first_reg_mismatch() != -1) begin
      tests_failed++;
      $display("[TB] FAIL oor_regs: reg %0d got %h expected %h", first_reg_mismatch(),
               reg_q[first_reg_mismatch()*DW +: DW], mdl[first_reg_mismatch()]);
    end
  endtask

  task automatic test_bready_stall();
    bit bad = 0;
    axi_write(32'h14, 32'h0000_0077, 4'hF, 0, 0);
    @(negedge aclk);
    fork
      begin
        for (int n = 0; n < 10; n++) begin
          if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) bad = 1;
          @(negedge aclk);
        end
      end
      begin
        axi_read(32'h8);
        collect_r();
        axi_read(32'h14);
        collect_r();
      end
    join
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("[TB] FAIL bready_stall: got unstable B or readies expected bv=1 bresp=00 rdy=00");
    end
    collect_b(0);
  endtask

  task automatic test_same_cycle();
    rexp_t re;
    axi_write(32'hC, 32'h5, 4'hF, 0, 0);
    collect_b(1);
    re.data = 32'h5;
    re.resp = 2'b00;
    r_exp.push_back(re);
    expect_write(32'hC, 32'h9, 4'hF);
    awaddr  = 32'hC;
    wdata   = 32'h9;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    araddr  = 32'hC;
    arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    fork
      collect_r();
      collect_b(1);
    join
    axi_read(32'hC);
    collect_r();
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    awaddr  = 32'h0;
    awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    tests_run++;
    if (awready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_aw_captured: got awready %b expected 0", awready);
    end
    aresetn = 1'b0;
    foreach (mdl[i]) mdl[i] = RV;
    @(negedge aclk);
    tests_run++;
    if (first_reg_mismatch() != -1 || {awready, wready, arready, bvalid} !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_state: got rdy/bv %b expected 0000 with regs at %h",
               {awready, wready, arready, bvalid}, RV);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL mid_ready: got %b expected 111", {awready, wready, arready});
    end
    for (int n = 0; n < 5; n++) begin
      if (bvalid !== 1'b0) bad = 1;
      @(negedge aclk);
    end
    tests_run++;
    if (bad || first_reg_mismatch() != -1) begin
      tests_failed++;
      $display("[TB] FAIL mid_no_commit: got bvalid seen=%b reg mismatch=%0d expected 0/-1",
               bad, first_reg_mismatch());
    end
  endtask

  initial begin
    test_reset();
    test_aw_then_w();
    test_strobe();
    test_out_of_range();
    test_bready_stall();
    test_same_cycle();
    test_reset_mid();
    tests_run++;
    if (b_exp.size() != 0 || r_exp.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d left expected 0/0", b_exp.size(), r_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
